// File: rtl/wr_slot_tracker.sv
// wr_slot_tracker: watchdog for one outstanding AXI write transaction.
// It walks the slot through AW -> W beats -> B and reloads a budget on each
// phase change. The budget counts down on the prescaled tick. When a budget
// runs out the slot parks in TIMEOUT until the monitor clears it. A mismatch
// between WLAST and the expected beat count raises a sticky protocol-error flag.
module wr_slot_tracker #(
  parameter int CntWidth = 10,
  parameter int IdWidth  = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                prescaled_en_i,
  input  logic [CntWidth-1:0] budget_w_first_i,
  input  logic [CntWidth-1:0] budget_w_last_i,
  input  logic [CntWidth-1:0] budget_b_i,
  input  logic                alloc_i,
  input  logic [IdWidth-1:0]  alloc_id_i,
  input  logic [7:0]          alloc_len_i,
  input  logic                is_w_head_i,
  input  logic                w_hs_i,
  input  logic                w_last_i,
  input  logic                is_b_head_i,
  input  logic                b_hs_i,
  input  logic [IdWidth-1:0]  b_id_i,
  input  logic                clear_i,
  output logic                free_o,
  output logic [IdWidth-1:0]  id_o,
  output logic [2:0]          phase_o,
  output logic [CntWidth-1:0] counter_o,
  output logic [8:0]          beats_left_o,
  output logic                w_done_o,
  output logic                done_o,
  output logic                timeout_o,
  output logic                proto_err_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_WAIT  = 3'd1,
    W_DATA  = 3'd2,
    B_WAIT  = 3'd3,
    TIMEOUT = 3'd4
  } phase_e;

  localparam logic [CntWidth-1:0] CntZero = {CntWidth{1'b0}};
  localparam logic [CntWidth-1:0] CntOne  = {{(CntWidth-1){1'b0}}, 1'b1};

  phase_e              phase_r;
  logic [IdWidth-1:0]  id_r;
  logic [CntWidth-1:0] counter_r;
  logic [8:0]          beats_left_r;
  logic                free_r;
  logic                w_done_r;
  logic                done_r;
  logic                timeout_r;
  logic                proto_err_r;

  logic                beat_s;
  logic                count_one_s;
  logic                last_beat_s;
  logic                b_match_s;
  logic                cnt_zero_s;

  // Decode this cycle's handshakes against the current phase.
  always_comb begin
    beat_s      = 1'b0;
    count_one_s = (beats_left_r == 9'd1);
    last_beat_s = w_last_i | count_one_s;
    b_match_s   = 1'b0;
    cnt_zero_s  = (counter_r == CntZero);
    if ((phase_r == W_WAIT) || (phase_r == W_DATA)) begin
      beat_s = is_w_head_i & w_hs_i;
    end else begin
      beat_s = 1'b0;
    end
    if (phase_r == B_WAIT) begin
      b_match_s = b_hs_i & is_b_head_i & (b_id_i == id_r);
    end else begin
      b_match_s = 1'b0;
    end
  end

  // Phase machine. Priority: clear, then handshake reload, then tick/timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_r      <= IDLE;
      id_r         <= {IdWidth{1'b0}};
      counter_r    <= CntZero;
      beats_left_r <= 9'd0;
      free_r       <= 1'b1;
      w_done_r     <= 1'b0;
      done_r       <= 1'b0;
      timeout_r    <= 1'b0;
      proto_err_r  <= 1'b0;
    end else begin
      w_done_r <= 1'b0;
      done_r   <= 1'b0;
      if (clear_i) begin
        phase_r      <= IDLE;
        counter_r    <= CntZero;
        beats_left_r <= 9'd0;
        free_r       <= 1'b1;
        timeout_r    <= 1'b0;
        proto_err_r  <= 1'b0;
      end else begin
        case (phase_r)
          IDLE: begin
            if (alloc_i) begin
              phase_r      <= W_WAIT;
              id_r         <= alloc_id_i;
              beats_left_r <= {1'b0, alloc_len_i} + 9'd1;
              counter_r    <= budget_w_first_i;
              free_r       <= 1'b0;
            end
          end
          W_WAIT, W_DATA: begin
            if (beat_s) begin
              beats_left_r <= beats_left_r - 9'd1;
              // WLAST and the beat count must agree on which beat is last.
              if (w_last_i != count_one_s) begin
                proto_err_r <= 1'b1;
              end
              if (last_beat_s) begin
                phase_r   <= B_WAIT;
                counter_r <= budget_b_i;
                w_done_r  <= 1'b1;
              end else begin
                phase_r   <= W_DATA;
                counter_r <= budget_w_last_i;
              end
            end else if (prescaled_en_i) begin
              if (cnt_zero_s) begin
                phase_r   <= TIMEOUT;
                timeout_r <= 1'b1;
              end else begin
                counter_r <= counter_r - CntOne;
              end
            end
          end
          B_WAIT: begin
            if (b_match_s) begin
              phase_r <= IDLE;
              done_r  <= 1'b1;
              free_r  <= 1'b1;
            end else if (prescaled_en_i) begin
              if (cnt_zero_s) begin
                phase_r   <= TIMEOUT;
                timeout_r <= 1'b1;
              end else begin
                counter_r <= counter_r - CntOne;
              end
            end
          end
          TIMEOUT: begin
            // Frozen for inspection until the monitor clears the slot.
            phase_r <= TIMEOUT;
          end
          default: begin
            phase_r <= IDLE;
            free_r  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign free_o       = free_r;
  assign id_o         = id_r;
  assign phase_o      = phase_r;
  assign counter_o    = counter_r;
  assign beats_left_o = beats_left_r;
  assign w_done_o     = w_done_r;
  assign done_o       = done_r;
  assign timeout_o    = timeout_r;
  assign proto_err_o  = proto_err_r;

endmodule

// File: tb/tb_wr_slot_tracker.sv
// Testbench for wr_slot_tracker. It runs directed scenarios followed by
// randomized traffic. A behavioural model predicts every cycle's outputs into
// a scoreboard queue, and a monitor pops and compares after each rising edge.
module tb_wr_slot_tracker;

  localparam int CW = 10;
  localparam int IW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          prescaled_en_i = 1'b0;
  logic [CW-1:0] budget_w_first_i = '0;
  logic [CW-1:0] budget_w_last_i = '0;
  logic [CW-1:0] budget_b_i = '0;
  logic          alloc_i = 1'b0;
  logic [IW-1:0] alloc_id_i = '0;
  logic [7:0]    alloc_len_i = '0;
  logic          is_w_head_i = 1'b0;
  logic          w_hs_i = 1'b0;
  logic          w_last_i = 1'b0;
  logic          is_b_head_i = 1'b0;
  logic          b_hs_i = 1'b0;
  logic [IW-1:0] b_id_i = '0;
  logic          clear_i = 1'b0;
  logic          free_o;
  logic [IW-1:0] id_o;
  logic [2:0]    phase_o;
  logic [CW-1:0] counter_o;
  logic [8:0]    beats_left_o;
  logic          w_done_o;
  logic          done_o;
  logic          timeout_o;
  logic          proto_err_o;

  wr_slot_tracker #(.CntWidth(CW), .IdWidth(IW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .prescaled_en_i(prescaled_en_i),
    .budget_w_first_i(budget_w_first_i), .budget_w_last_i(budget_w_last_i),
    .budget_b_i(budget_b_i), .alloc_i(alloc_i), .alloc_id_i(alloc_id_i),
    .alloc_len_i(alloc_len_i), .is_w_head_i(is_w_head_i), .w_hs_i(w_hs_i),
    .w_last_i(w_last_i), .is_b_head_i(is_b_head_i), .b_hs_i(b_hs_i),
    .b_id_i(b_id_i), .clear_i(clear_i), .free_o(free_o), .id_o(id_o),
    .phase_o(phase_o), .counter_o(counter_o), .beats_left_o(beats_left_o),
    .w_done_o(w_done_o), .done_o(done_o), .timeout_o(timeout_o),
    .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          free;
    logic [IW-1:0] id;
    logic [2:0]    phase;
    logic [CW-1:0] cnt;
    logic [8:0]    beats;
    logic          wd;
    logic          dn;
    logic          to;
    logic          pe;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model state: phase numbers follow the documented phase_o codes.
  int        m_phase;
  int        m_cnt;
  int        m_beats;
  logic [IW-1:0] m_id;
  bit        m_free, m_to, m_pe, m_wd, m_dn;

  function automatic exp_t model_snapshot();
    exp_t e;
    e.free  = m_free;
    e.id    = m_id;
    e.phase = 3'(m_phase);
    e.cnt   = CW'(m_cnt);
    e.beats = 9'(m_beats);
    e.wd    = m_wd;
    e.dn    = m_dn;
    e.to    = m_to;
    e.pe    = m_pe;
    return e;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_beats = 0; m_id = '0;
    m_free = 1'b1; m_to = 1'b0; m_pe = 1'b0; m_wd = 1'b0; m_dn = 1'b0;
  endtask

  // A waiting phase spends one tick of budget; an empty budget means timeout.
  task automatic model_tick();
    if (prescaled_en_i) begin
      if (m_cnt == 0) begin
        m_phase = 4;
        m_to = 1'b1;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  // Apply the current inputs to the model; return what the DUT shows after the edge.
  task automatic model_step();
    bit expect_last, is_last;
    m_wd = 1'b0;
    m_dn = 1'b0;
    if (clear_i) begin
      m_phase = 0; m_free = 1'b1; m_to = 1'b0; m_pe = 1'b0;
      m_cnt = 0; m_beats = 0;
    end else if (m_phase == 0) begin
      if (alloc_i) begin
        m_phase = 1; m_id = alloc_id_i; m_beats = int'(alloc_len_i) + 1;
        m_cnt = int'(budget_w_first_i); m_free = 1'b0;
      end
    end else if (m_phase == 1 || m_phase == 2) begin
      if (is_w_head_i && w_hs_i) begin
        expect_last = (m_beats == 1);
        is_last = w_last_i || expect_last;
        if (w_last_i != expect_last) m_pe = 1'b1;
        m_beats = m_beats - 1;
        if (is_last) begin
          m_phase = 3; m_cnt = int'(budget_b_i); m_wd = 1'b1;
        end else begin
          m_phase = 2; m_cnt = int'(budget_w_last_i);
        end
      end else begin
        model_tick();
      end
    end else if (m_phase == 3) begin
      if (b_hs_i && is_b_head_i && b_id_i == m_id) begin
        m_phase = 0; m_dn = 1'b1; m_free = 1'b1;
      end else begin
        model_tick();
      end
    end
  endtask

  task automatic idle_inputs();
    prescaled_en_i = 1'b0; alloc_i = 1'b0; is_w_head_i = 1'b0; w_hs_i = 1'b0;
    w_last_i = 1'b0; is_b_head_i = 1'b0; b_hs_i = 1'b0; clear_i = 1'b0;
  endtask

  // Inputs are already driven (just after a falling edge): predict, then advance one cycle.
  task automatic step_cycle();
    model_step();
    exp_q.push_back(model_snapshot());
    @(negedge clk_i);
    idle_inputs();
  endtask

  function automatic exp_t dut_snapshot();
    exp_t a;
    a.free = free_o; a.id = id_o; a.phase = phase_o; a.cnt = counter_o;
    a.beats = beats_left_o; a.wd = w_done_o; a.dn = done_o;
    a.to = timeout_o; a.pe = proto_err_o;
    return a;
  endfunction

  task automatic compare(input string name, input exp_t act, input exp_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got free=%b id=%0d ph=%0d cnt=%0d beats=%0d wd=%b dn=%b to=%b pe=%b want free=%b id=%0d ph=%0d cnt=%0d beats=%0d wd=%b dn=%b to=%b pe=%b",
               name, $time, act.free, act.id, act.phase, act.cnt, act.beats, act.wd, act.dn,
               act.to, act.pe, exp.free, exp.id, exp.phase, exp.cnt, exp.beats, exp.wd,
               exp.dn, exp.to, exp.pe);
    end
  endtask

  // Monitor: after every rising edge pop the prediction for that edge and compare.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) compare("cycle", dut_snapshot(), exp_q.pop_front());
    end
  end

  task automatic do_alloc(input logic [IW-1:0] id, input logic [7:0] len,
                          input int bf, input int bl, input int bb);
    alloc_i = 1'b1; alloc_id_i = id; alloc_len_i = len;
    budget_w_first_i = CW'(bf); budget_w_last_i = CW'(bl); budget_b_i = CW'(bb);
    step_cycle();
  endtask

  task automatic do_beat(input logic last);
    is_w_head_i = 1'b1; w_hs_i = 1'b1; w_last_i = last;
    step_cycle();
  endtask

  task automatic do_b(input logic [IW-1:0] id, input logic head);
    b_hs_i = 1'b1; is_b_head_i = head; b_id_i = id;
    step_cycle();
  endtask

  exp_t rst_exp;

  initial begin
    model_reset();
    rst_exp = model_snapshot();
    #12;
    compare("reset_values", dut_snapshot(), rst_exp);
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle_inputs();

    // Normal 4-beat write then matching B.
    do_alloc(4'd5, 8'd3, 5, 5, 5);
    for (int i = 0; i < 4; i++) do_beat(i == 3);
    step_cycle();
    do_b(4'd5, 1'b1);
    step_cycle();

    // No W data: budget 2 drains with a tick every 4 cycles, then times out.
    do_alloc(4'd2, 8'd0, 2, 5, 5);
    for (int i = 0; i < 16; i++) begin
      prescaled_en_i = (i % 4 == 3);
      step_cycle();
    end
    do_beat(1'b1);
    do_b(4'd2, 1'b1);
    clear_i = 1'b1;
    step_cycle();

    // WLAST early / late protocol errors.
    do_alloc(4'd1, 8'd0, 5, 5, 5);
    do_beat(1'b0);
    do_b(4'd1, 1'b1);
    clear_i = 1'b1;
    step_cycle();
    do_alloc(4'd3, 8'd3, 5, 5, 5);
    do_beat(1'b0);
    do_beat(1'b1);
    step_cycle();

    // B filtering, then matching B together with a zero-count tick.
    do_b(4'd4, 1'b1);
    do_b(4'd3, 1'b0);
    clear_i = 1'b1;
    step_cycle();
    do_alloc(4'd7, 8'd0, 5, 5, 0);
    do_beat(1'b1);
    do_b(4'd6, 1'b1);
    do_b(4'd7, 1'b0);
    b_hs_i = 1'b1; is_b_head_i = 1'b1; b_id_i = 4'd7; prescaled_en_i = 1'b1;
    step_cycle();

    // Non-head beat ignored; beat with tick in W_DATA reloads.
    do_alloc(4'd9, 8'd2, 4, 3, 5);
    w_hs_i = 1'b1; is_w_head_i = 1'b0;
    step_cycle();
    do_beat(1'b0);
    prescaled_en_i = 1'b1;
    step_cycle();
    prescaled_en_i = 1'b1; is_w_head_i = 1'b1; w_hs_i = 1'b1;
    step_cycle();

    // Async reset mid-W_DATA, seen before the next rising edge.
    do_alloc(4'd8, 8'd4, 5, 5, 5);
    do_beat(1'b0);
    rst_ni = 1'b0;
    #1;
    compare("async_reset", dut_snapshot(), rst_exp);
    model_reset();
    exp_q.push_back(model_snapshot());
    @(negedge clk_i);
    rst_ni = 1'b1;
    do_alloc(4'd10, 8'd1, 5, 5, 5);
    do_beat(1'b0);
    do_beat(1'b1);
    do_b(4'd10, 1'b1);
    step_cycle();

    // Randomized traffic, biased toward well-formed transactions.
    for (int i = 0; i < 3000; i++) begin
      prescaled_en_i   = ($urandom_range(0, 9) < 3);
      alloc_i          = ($urandom_range(0, 9) < 3);
      alloc_id_i       = IW'($urandom_range(0, 15));
      alloc_len_i      = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                      : 8'($urandom_range(0, 3));
      budget_w_first_i = CW'($urandom_range(0, 6));
      budget_w_last_i  = CW'($urandom_range(0, 6));
      budget_b_i       = CW'($urandom_range(0, 6));
      is_w_head_i      = ($urandom_range(0, 9) < 8);
      w_hs_i           = ($urandom_range(0, 9) < 4);
      w_last_i         = (m_beats == 1) ? ($urandom_range(0, 9) != 0)
                                        : ($urandom_range(0, 9) == 0);
      b_hs_i           = ($urandom_range(0, 9) < 3);
      is_b_head_i      = ($urandom_range(0, 9) < 8);
      b_id_i           = ($urandom_range(0, 9) < 8) ? m_id : IW'($urandom_range(0, 15));
      clear_i          = ($urandom_range(0, 49) == 0);
      step_cycle();
    end

    @(negedge clk_i);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
